// File: rtl/groovy_sched_pkg.sv
// Shared constants and the scheduler state type for groovy_cmd_sched.
package groovy_sched_pkg;

    localparam int NUM_ENG      = 4;
    localparam int ENG_SWITCHRES = 0;
    localparam int ENG_AUDIO     = 1;
    localparam int ENG_BLIT      = 2;
    localparam int ENG_BLIT_LZ4  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        ACK   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/groovy_sched_pick.sv
// Combinational winner selection: switchres (in vblank), then audio, then
// round-robin between blit and blit_lz4.
module groovy_sched_pick
    import groovy_sched_pkg::*;
(
    input  logic [NUM_ENG-1:0] req,
    input  logic               vga_vblank,
    input  logic               rr_lz4,
    output logic [NUM_ENG-1:0] pick,
    output logic               pick_valid
);

    always_comb begin
        pick = '0;
        if (req[ENG_SWITCHRES] && vga_vblank) begin
            pick[ENG_SWITCHRES] = 1'b1;
        end else if (req[ENG_AUDIO]) begin
            pick[ENG_AUDIO] = 1'b1;
        end else if (!req[ENG_SWITCHRES]) begin
            // A waiting switchres holds off both blit classes so it reaches the next vblank.
            if (req[ENG_BLIT] && (!req[ENG_BLIT_LZ4] || rr_lz4)) begin
                pick[ENG_BLIT] = 1'b1;
            end else if (req[ENG_BLIT_LZ4]) begin
                pick[ENG_BLIT_LZ4] = 1'b1;
            end
        end
    end

    assign pick_valid = |pick;

endmodule

// File: rtl/groovy_cmd_sched.sv
// Command scheduler: grants the shared DDR port to one engine per command and
// acknowledges the HPS decoder. Optional counters: GROOVY_SCHED_STATS_EN.
module groovy_cmd_sched
    import groovy_sched_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               cmd_switchres,
    input  logic               cmd_audio,
    input  logic               cmd_blit,
    input  logic               cmd_blit_lz4,
    input  logic               vga_vblank,
    input  logic [NUM_ENG-1:0] eng_done,
    input  logic               clr_err,
    output logic               reset_switchres,
    output logic               reset_audio,
    output logic               reset_blit,
    output logic               reset_blit_lz4,
    output logic [NUM_ENG-1:0] eng_start,
    output logic [NUM_ENG-1:0] grant,
    output logic               busy,
    output logic               timeout_err
`ifdef GROOVY_SCHED_STATS_EN
    ,
    output logic [63:0]        stat_grants,
    output logic [15:0]        stat_timeouts
`endif
);

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = TIMEOUT_W'(1);

    sched_state_t         state;
    logic [NUM_ENG-1:0]   req;
    logic [NUM_ENG-1:0]   pick;
    logic                 pick_valid;
    logic [NUM_ENG-1:0]   ack;
    logic [TIMEOUT_W-1:0] timer;
    logic                 rr_lz4;
    logic                 done_hit;
    logic                 expire;

    assign req = {cmd_blit_lz4, cmd_blit, cmd_audio, cmd_switchres};

    groovy_sched_pick u_pick (
        .req        (req),
        .vga_vblank (vga_vblank),
        .rr_lz4     (rr_lz4),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // grant is zero outside GRANT/RUN, so done bits of other engines never match.
    assign done_hit = |(eng_done & grant) && (state == RUN);
    assign expire   = (state == RUN) && (timer == TIMER_LAST) && !done_hit;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            eng_start   <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            timer       <= '0;
            rr_lz4      <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            eng_start <= '0;
            ack       <= '0;
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        grant     <= pick;
                        eng_start <= pick;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= RUN;
                    timer <= '0;
                    if (grant[ENG_BLIT] || grant[ENG_BLIT_LZ4]) begin
                        rr_lz4 <= grant[ENG_BLIT_LZ4];
                    end
                end
                RUN: begin
                    timer <= timer + TIMER_ONE;
                    if (done_hit || (timer == TIMER_LAST)) begin
                        state <= ACK;
                        ack   <= grant;
                        grant <= '0;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reset_switchres = ack[ENG_SWITCHRES];
    assign reset_audio     = ack[ENG_AUDIO];
    assign reset_blit      = ack[ENG_BLIT];
    assign reset_blit_lz4  = ack[ENG_BLIT_LZ4];

`ifdef GROOVY_SCHED_STATS_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (state == GRANT) begin
                for (int i = 0; i < NUM_ENG; i++) begin
                    if (grant[i]) begin
                        stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
                    end
                end
            end
            if (expire) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_groovy_cmd_sched.sv
// Randomized bench for groovy_cmd_sched with a timestamp-based reference model
// and start/ack scoreboards; also checks GROOVY_SCHED_STATS_EN counters if built.
module tb_groovy_cmd_sched;
    import groovy_sched_pkg::*;

    localparam int TW     = 24;
    localparam int T      = 16;
    localparam int N_ITER = 1500;
    localparam int N_MAX  = N_ITER + 400;

    logic       clk_sys    = 1'b0;
    logic       reset_n    = 1'b0;
    logic [3:0] cmd        = '0;
    logic       vga_vblank = 1'b0;
    logic [3:0] eng_done   = '0;
    logic       clr_err    = 1'b0;

    logic       reset_switchres, reset_audio, reset_blit, reset_blit_lz4;
    logic [3:0] eng_start, grant, rs;
    logic       busy, timeout_err;
`ifdef GROOVY_SCHED_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_timeouts;
`endif

    assign rs = {reset_blit_lz4, reset_blit, reset_audio, reset_switchres};

    groovy_cmd_sched #(.TIMEOUT_W(TW), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .cmd_switchres   (cmd[0]),
        .cmd_audio       (cmd[1]),
        .cmd_blit        (cmd[2]),
        .cmd_blit_lz4    (cmd[3]),
        .vga_vblank      (vga_vblank),
        .eng_done        (eng_done),
        .clr_err         (clr_err),
        .reset_switchres (reset_switchres),
        .reset_audio     (reset_audio),
        .reset_blit      (reset_blit),
        .reset_blit_lz4  (reset_blit_lz4),
        .eng_start       (eng_start),
        .grant           (grant),
        .busy            (busy),
        .timeout_err     (timeout_err)
`ifdef GROOVY_SCHED_STATS_EN
        ,
        .stat_grants     (stat_grants),
        .stat_timeouts   (stat_timeouts)
`endif
    );

    // clock / edge counter
    always #5 clk_sys = ~clk_sys;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // scoreboard state
    logic [35:0] start_q[$];
    logic [35:0] ack_q[$];
    int checks = 0;
    int passed = 0;

    // reference model state, expressed as edge timestamps
    logic [3:0] mv_grant = '0;
    logic       mv_busy  = 1'b0;
    logic       mv_err   = 1'b0;
    bit         m_serving = 1'b0;
    bit         m_acked   = 1'b0;
    int         m_eng, m_pick_edge, m_ack_edge;
    int         m_last_blit = 3;
    int         done_at[4];
    int         exp_grants[4];
    int         exp_timeouts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int ref_pick(input logic [3:0] c, input logic vb, input int last_blit);
        if (c[0] && vb) return 0;
        if (c[1]) return 1;
        if (c[0]) return -1;
        if (c[2] && c[3]) return (last_blit == 2) ? 3 : 2;
        if (c[2]) return 2;
        if (c[3]) return 3;
        return -1;
    endfunction

    // Predict what the DUT does on edge e given the inputs now applied.
    task automatic model_edge(input int e);
        int  w;
        bit  d, x, expire_nd;
        expire_nd = 1'b0;
        if (m_serving && m_acked) begin
            if (e == m_ack_edge + 1) begin
                m_serving = 1'b0;
                mv_busy   = 1'b0;
            end
        end else if (m_serving) begin
            if (e >= m_pick_edge + 2) begin
                d = eng_done[m_eng];
                x = (e == m_pick_edge + 1 + T);
                if (d || x) begin
                    m_acked    = 1'b1;
                    m_ack_edge = e;
                    ack_q.push_back({e[31:0], onehot(m_eng)});
                    mv_grant   = '0;
                    expire_nd  = !d;
                    if (!d) exp_timeouts++;
                end
            end
        end else begin
            w = ref_pick(cmd, vga_vblank, m_last_blit);
            if (w >= 0) begin
                m_serving   = 1'b1;
                m_acked     = 1'b0;
                m_eng       = w;
                m_pick_edge = e;
                start_q.push_back({e[31:0], onehot(w)});
                mv_grant    = onehot(w);
                mv_busy     = 1'b1;
                exp_grants[w]++;
                if (w >= 2) m_last_blit = w;
            end
        end
        if (expire_nd) mv_err = 1'b1;
        else if (clr_err) mv_err = 1'b0;
    endtask

    task automatic model_reset();
        m_serving    = 1'b0;
        m_acked      = 1'b0;
        m_last_blit  = 3;
        mv_grant     = '0;
        mv_busy      = 1'b0;
        mv_err       = 1'b0;
        exp_timeouts = 0;
        for (int i = 0; i < 4; i++) begin
            done_at[i]    = -1;
            exp_grants[i] = 0;
        end
    endtask

    // monitor: per-cycle level check plus scoreboard pops on pulses
    always @(negedge clk_sys) begin : mon
        logic [35:0] e;
        check("grant_busy_err", {grant, busy, timeout_err}, {mv_grant, mv_busy, mv_err});
        if (eng_start != 4'd0) begin
            if (start_q.size() == 0) check("start_unexpected", {32'd0, eng_start}, 36'd0);
            else begin
                e = start_q.pop_front();
                check("eng_start", {cyc, eng_start}, e);
            end
        end
        if (rs != 4'd0) begin
            if (ack_q.size() == 0) check("ack_unexpected", {32'd0, rs}, 36'd0);
            else begin
                e = ack_q.pop_front();
                check("reset_pulse", {cyc, rs}, e);
            end
        end
    end

    // driver: decoder, engines, random commands, reset injection
    initial begin : drv
        bit did_reset;
        did_reset = 1'b0;
        model_reset();
        for (int it = 0; it < N_MAX; it++) begin
            @(negedge clk_sys);
            #1;
            if (rs[0]) cmd[0] = 1'b0;
            if (rs[1]) cmd[1] = 1'b0;
            if (rs[2]) cmd[2] = 1'b0;
            if (rs[3]) cmd[3] = 1'b0;
            for (int i = 0; i < 4; i++)
                if (eng_start[i]) done_at[i] = cyc + int'($urandom_range(1, T + 4));
            if (it < N_ITER) begin
                for (int i = 0; i < 4; i++) begin
                    if (!cmd[i] && $urandom_range(0, 7) == 0) cmd[i] = 1'b1;
                    else if (cmd[i] && $urandom_range(0, 63) == 0) cmd[i] = 1'b0;
                end
                if ($urandom_range(0, 7) == 0) vga_vblank = ~vga_vblank;
                clr_err = ($urandom_range(0, 19) == 0);
            end else begin
                vga_vblank = 1'b1;
                clr_err    = 1'b0;
                if (!m_serving && cmd == 4'd0) break;
            end
            for (int i = 0; i < 4; i++)
                eng_done[i] = (done_at[i] == cyc + 1) || (it < N_ITER && $urandom_range(0, 15) == 0);

            if (it < 2) begin
                if (it == 1) check("reset_outputs", {eng_start, rs, grant, busy, timeout_err}, 14'd0);
            end else if (!reset_n) begin
                reset_n = 1'b1;
                model_edge(cyc + 1);
            end else if (!did_reset && it >= 400 && m_serving && !m_acked && cyc + 1 >= m_pick_edge + 3) begin
                did_reset = 1'b1;
                #2 reset_n = 1'b0;
                #1 check("async_reset_mid_run", {grant, busy, eng_start, rs, timeout_err}, 14'd0);
                model_reset();
            end else begin
                model_edge(cyc + 1);
            end
        end
        repeat (3) @(negedge clk_sys);
        #1;
        check("final_idle", {busy, grant}, 5'd0);
        check("start_q_empty", start_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);
        check("reset_injected", did_reset, 1);
`ifdef GROOVY_SCHED_STATS_EN
        for (int i = 0; i < 4; i++)
            check("stat_grants", stat_grants[16*i +: 16], exp_grants[i][15:0]);
        check("stat_timeouts", stat_timeouts, exp_timeouts[15:0]);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
